// File: rtl/pc_branch_pkg.sv
// Shared branch-type codes and FSM states for the PC / branch-resolution stage.
package pc_branch_pkg;

    localparam int unsigned BT_W = 4;

    // Branch-type encodings; 10..15 are unused and behave as NONE.
    localparam logic [BT_W-1:0] BT_NONE = 4'd0;
    localparam logic [BT_W-1:0] BT_BR   = 4'd1;
    localparam logic [BT_W-1:0] BT_BLTZ = 4'd2;
    localparam logic [BT_W-1:0] BT_BZ   = 4'd3;
    localparam logic [BT_W-1:0] BT_BNZ  = 4'd4;
    localparam logic [BT_W-1:0] BT_BL   = 4'd5;
    localparam logic [BT_W-1:0] BT_BCY  = 4'd6;
    localparam logic [BT_W-1:0] BT_BNCY = 4'd7;
    localparam logic [BT_W-1:0] BT_JR   = 4'd8;
    localparam logic [BT_W-1:0] BT_HALT = 4'd9;

    // RUN/HALT machine; HALT is only left through reset.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/pc_branch_unit_cond.sv
// Branch condition evaluation: pure combinational decode of br_type against flags.
module branch_cond_eval
    import pc_branch_pkg::*;
(
    input  logic [BT_W-1:0] br_type,
    input  logic            carry_q,
    input  logic            zero_in,
    input  logic            sign_in,
    output logic            taken_raw
);

    // Live flags for sign/zero tests, latched carry for carry tests.
    always_comb begin
        taken_raw = 1'b0;
        case (br_type)
            BT_BR, BT_BL, BT_JR: taken_raw = 1'b1;
            BT_BLTZ:             taken_raw = sign_in;
            BT_BZ:               taken_raw = zero_in;
            BT_BNZ:              taken_raw = ~zero_in;
            BT_BCY:              taken_raw = carry_q;
            BT_BNCY:             taken_raw = ~carry_q;
            default:             taken_raw = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, flag latch, RUN/HALT machine and next-PC selection.
module pc_branch_unit
    import pc_branch_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     OFF_W    = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [BT_W-1:0]   br_type,
    input  logic [OFF_W-1:0]  br_off,
    input  logic [PC_W-1:0]   reg_tgt,
    input  logic              flag_we,
    input  logic              carry_in,
    input  logic              zero_in,
    input  logic              sign_in,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus4,
    output logic              taken,
    output logic              link_we,
    output logic [PC_W-1:0]   link_addr,
    output logic              carry_q,
    output logic              zero_q,
    output logic              sign_q,
    output logic              halted
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

    state_t          state;
    logic            advance;
    logic            taken_raw;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] rel_tgt;
    logic [PC_W-1:0] jr_tgt;
    logic [PC_W-1:0] next_pc;

    branch_cond_eval u_cond (
        .br_type   (br_type),
        .carry_q   (carry_q),
        .zero_in   (zero_in),
        .sign_in   (sign_in),
        .taken_raw (taken_raw)
    );

    // Sequential-PC and branch-target arithmetic; all sums wrap modulo 2^PC_W.
    always_comb begin
        pc_plus4 = pc + PC_STEP;
        off_ext  = PC_W'($signed(br_off));
        rel_tgt  = (pc_plus4 + off_ext) & ALIGN_MASK;
        jr_tgt   = reg_tgt & ALIGN_MASK;
    end

    // Redirect and link strobes are only live while running and not stalled.
    always_comb begin
        advance   = en & (state == ST_RUN);
        taken     = advance & taken_raw;
        link_we   = advance & (br_type == BT_BL);
        link_addr = pc_plus4;
    end

    // Next-PC mux; a HALT instruction leaves the PC where it is.
    always_comb begin
        next_pc = pc_plus4;
        if (br_type == BT_HALT) begin
            next_pc = pc;
        end else if (taken_raw) begin
            next_pc = (br_type == BT_JR) ? jr_tgt : rel_tgt;
        end
    end

    // PC, flag latch and RUN/HALT machine; everything holds on stall or in HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            halted  <= 1'b0;
            pc      <= RESET_PC;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (en) begin
                        pc <= next_pc;
                        if (flag_we) begin
                            carry_q <= carry_in;
                            zero_q  <= zero_in;
                            sign_q  <= sign_in;
                        end
                        if (br_type == BT_HALT) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: directed scenarios plus randomized traffic.
module tb_pc_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  br_type;
    logic [25:0] br_off;
    logic [31:0] reg_tgt;
    logic        flag_we, carry_in, zero_in, sign_in;
    logic [31:0] pc, pc_plus4, link_addr;
    logic        taken, link_we, carry_q, zero_q, sign_q, halted;

    pc_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .br_type(br_type), .br_off(br_off),
        .reg_tgt(reg_tgt), .flag_we(flag_we), .carry_in(carry_in),
        .zero_in(zero_in), .sign_in(sign_in), .pc(pc), .pc_plus4(pc_plus4),
        .taken(taken), .link_we(link_we), .link_addr(link_addr),
        .carry_q(carry_q), .zero_q(zero_q), .sign_q(sign_q), .halted(halted)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] link_addr;
        logic        taken;
        logic        link_we;
        logic        c, z, s;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference architectural state.
    logic [31:0] m_pc;
    logic        m_c, m_z, m_s, m_halt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Issue one instruction for one cycle and record what the DUT must show.
    task automatic drive(input logic e, input logic [3:0] bt, input logic [25:0] off,
                         input logic [31:0] tgt, input logic fwe,
                         input logic c, input logic z, input logic s);
        exp_t        x;
        logic        cond;
        logic [31:0] sx, nxt;
        @(negedge clk);
        en = e; br_type = bt; br_off = off; reg_tgt = tgt;
        flag_we = fwe; carry_in = c; zero_in = z; sign_in = s;
        case (bt)
            4'd1, 4'd5, 4'd8: cond = 1'b1;
            4'd2:             cond = s;
            4'd3:             cond = z;
            4'd4:             cond = !z;
            4'd6:             cond = m_c;
            4'd7:             cond = !m_c;
            default:          cond = 1'b0;
        endcase
        sx = {{6{off[25]}}, off};
        if (bt == 4'd9)           nxt = m_pc;
        else if (cond && bt == 8) nxt = tgt & 32'hFFFF_FFFC;
        else if (cond)            nxt = (m_pc + 32'd4 + sx) & 32'hFFFF_FFFC;
        else                      nxt = m_pc + 32'd4;
        x.pc        = m_pc;
        x.pc_plus4  = m_pc + 32'd4;
        x.link_addr = m_pc + 32'd4;
        x.taken     = e && !m_halt && cond;
        x.link_we   = e && !m_halt && (bt == 4'd5);
        x.c = m_c; x.z = m_z; x.s = m_s;
        x.halted    = m_halt;
        sb.push_back(x);
        if (e && !m_halt) begin
            m_pc = nxt;
            if (bt == 4'd9) m_halt = 1'b1;
            if (fwe) begin m_c = c; m_z = z; m_s = s; end
        end
    endtask

    task automatic jump_to(input logic [31:0] a);
        drive(1'b1, 4'd8, 26'd0, a, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 4'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Async reset pulse in the middle of the low clock phase, checked immediately.
    task automatic pulse_reset();
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_flags", 32'({carry_q, zero_q, sign_q}), 32'h0);
        m_pc = 32'h0; m_c = 1'b0; m_z = 1'b0; m_s = 1'b0; m_halt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare each recorded expectation just before the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus4", pc_plus4, e.pc_plus4);
                chk("link_addr", link_addr, e.link_addr);
                chk("taken", 32'(taken), 32'(e.taken));
                chk("link_we", 32'(link_we), 32'(e.link_we));
                chk("flags", 32'({carry_q, zero_q, sign_q}), 32'({e.c, e.z, e.s}));
                chk("halted", 32'(halted), 32'(e.halted));
            end
        end
    end

    initial begin
        logic [3:0] bt;
        rst_n = 1'b0; en = 1'b0; br_type = 4'd0; br_off = '0; reg_tgt = '0;
        flag_we = 1'b0; carry_in = 1'b0; zero_in = 1'b0; sign_in = 1'b0;
        m_pc = 32'h0; m_c = 1'b0; m_z = 1'b0; m_s = 1'b0; m_halt = 1'b0;
        pulse_reset();

        // Sequential fetch from reset: 0, 4, 8, 12.
        nop(4);

        // BR -8 at 0x40 -> 0x3C; BL +0x10 at 0x3C -> link 0x40, pc 0x50.
        jump_to(32'h40);
        drive(1'b1, 4'd1, 26'h3FF_FFF8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 26'h10, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(1);

        // Carry bypass: BCY with simultaneous flag write uses the old carry.
        jump_to(32'h100);
        drive(1'b1, 4'd6, 26'h20, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'd6, 26'h20, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd7, 26'h20, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Live-flag branches and JR alignment.
        drive(1'b1, 4'd3, 26'h40, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'd4, 26'h40, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'd2, 26'h3FF_FFF0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'd8, 26'd0, 32'h0000_0203, 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap of pc+4 and an undefined code acting as NONE.
        jump_to(32'hFFFF_FFFC);
        nop(1);
        drive(1'b1, 4'hC, 26'h80, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b1);
        nop(1);

        // Stall with a BR presented, then reset while stalled.
        drive(1'b0, 4'd1, 26'h80, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 4'd1, 26'h80, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        nop(1);
        pulse_reset();
        nop(2);

        // Randomized traffic, HALT excluded so the machine keeps running.
        for (int i = 0; i < 400; i++) begin
            bt = 4'($urandom_range(0, 15));
            if (bt == 4'd9) bt = 4'hA;
            drive(($urandom_range(0, 7) != 0), bt, 26'($urandom), $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // HALT freezes everything; BR and flag writes afterwards do nothing.
        jump_to(32'h800);
        drive(1'b1, 4'd9, 26'h40, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 26'h40, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 4'd5, 26'h40, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(1);
        pulse_reset();
        nop(2);

        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        #5;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage that sits directly downstream of the ALU in the single-cycle datapath.
- Latches the ALU carry/zero/sign flags and holds the PC.
- Evaluates the branch condition for the current instruction and produces the next PC, plus the link write for branch-and-link.
- Has a RUN/HALT state machine and a stall input, so the fetch side can freeze the PC.

Parameters:
- PC_W, 32, width of PC, targets and offsets
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- OFF_W, 26, width of the signed PC-relative branch offset field (byte offset)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  advance enable; 0 = stall, all state held
- br_type  input  4  branch code, encodings from shared package
- br_off  input  OFF_W  signed byte offset, PC-relative to pc+4
- reg_tgt  input  PC_W  register target for JR
- flag_we  input  1  latch ALU flags this cycle
- carry_in  input  1  ALU carry
- zero_in  input  1  ALU zero
- sign_in  input  1  ALU sign
- pc  output  PC_W  current PC (registered)
- pc_plus4  output  PC_W  pc+4, combinational
- taken  output  1  current instruction redirects PC, combinational
- link_we  output  1  write pc_plus4 to link register, combinational
- link_addr  output  PC_W  equals pc_plus4
- carry_q  output  1  latched carry (registered)
- zero_q  output  1  latched zero (registered)
- sign_q  output  1  latched sign (registered)
- halted  output  1  1 while FSM in HALT (registered)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, carry_q=zero_q=sign_q=0, state=RUN, halted=0. Asserting reset mid-stall or mid-HALT has the same effect immediately. Deassertion is sampled on the next rising edge.
- States:
  - RUN -> HALT when en=1 and br_type=HALT.
  - HALT is sticky; it is left only by reset.
- br_type codes (shared package): NONE=0, BR=1, BLTZ=2, BZ=3, BNZ=4, BL=5, BCY=6, BNCY=7, JR=8, HALT=9. Codes 10-15 are treated as NONE.
- rel_tgt = pc + 4 + sign_extend(br_off), computed modulo 2^PC_W (wrap-around, no error). Low 2 bits are forced to 0.
- jr_tgt = reg_tgt with low 2 bits forced to 0.
- taken (in RUN only):
  - BR, BL, JR: 1.
  - BLTZ: sign_in. BZ: zero_in. BNZ: !zero_in. These use the live ALU flags of the current instruction; the ALU passes rs through.
  - BCY: carry_q. BNCY: !carry_q. These use the latched carry from an earlier instruction.
  - All other codes: 0.
- next_pc: jr_tgt if JR taken; rel_tgt if other taken; pc_plus4 otherwise; pc if br_type=HALT.
- Rising edge with en=1 and state RUN:
  - pc <= next_pc.
  - If flag_we: {carry_q, zero_q, sign_q} <= inputs.
- Same cycle flag_we=1 with BCY/BNCY: the condition uses the old carry_q; the new value is visible from the next cycle.
- en=0: pc, flags and state hold; taken=0; link_we=0.
- HALT state: pc frozen; taken=0; link_we=0; flag_we ignored; halted=1 from the cycle after the HALT instruction.
- link_we = en & RUN & (br_type==BL). link_addr = pc_plus4 of the BL instruction. The register file writes it on the same edge.
- Latency: next PC is visible one cycle after the instruction; flags are visible one cycle after flag_we.
- pc+4 at 32'hFFFF_FFFC wraps to 0.

Decomposition:
- Shared package pc_branch_pkg holds:
  - the br_type localparams (BT_NONE..BT_HALT), 4 bits;
  - FSM state encodings ST_RUN=1'b0, ST_HALT=1'b1.
- One sub-module, branch_cond_eval: purely combinational. Inputs br_type, live flags and carry_q; outputs taken_raw.
- The top module holds the registers, FSM and next-PC mux. Reuse the team's existing 32-bit adder for pc+4 and rel_tgt.

Test Plan:
- Reset release, en=1, br_type=NONE for 3 cycles -> pc goes 0, 4, 8, 12; flags 0; halted=0.
- pc=0x40, BR with br_off=-8 -> taken=1; next pc=0x3C. Then BL with br_off=0x10 at pc=0x3C -> link_we=1, link_addr=0x40, next pc=0x50.
- Carry bypass: flag_we=1, carry_in=1 with BCY in the same cycle while carry_q=0 -> not taken, pc+4, carry_q=1 after the edge. Next cycle BCY, br_off=0x20 at pc=0x104 -> pc=0x128.
- BZ with zero_in=1 -> taken; BNZ with zero_in=1 -> not taken. JR with reg_tgt=0x0000_0203 -> pc=0x200.
- Stall and halt:
  - en=0 for 2 cycles with BR present -> pc and flags unchanged, taken=0.
  - Then HALT -> pc frozen, halted=1; a BR afterwards does nothing.
  - Async rst_n pulse mid-cycle -> pc=RESET_PC immediately, halted=0.
- Wrap: pc=0xFFFF_FFFC, NONE -> pc=0. Undefined code 4'hC -> behaves as NONE.
